mau_lsu: RTL and testbench
==========================

Name: mau_lsu

Overview:
- Memory access unit directly downstream of the ALU. Consumes the computed load/store address (addr_toMAU) and the store data (data_toMAU).
- Runs a single-outstanding request/ack transaction on the data-memory bus.
- Generates byte strobes and lane-replicated write data for stores; sign/zero-extends load data.
- Returns the load result, or an error, to writeback. Stalls the pipeline while a transaction is in flight.

Parameters:
- TIMEOUT_CYCLES, 16: cycles mem_req may stay high without mem_ack before the access is aborted with an error. Legal range 2..255.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- mau_valid  input  1  upstream presents a memory op this cycle
- riscv_LOAD  input  1  op is a load
- riscv_STORE  input  1  op is a store
- funct3  input  3  access size/sign (RV32I load/store encoding)
- addr_toMAU  input  32  byte address from ALU
- data_toMAU  input  32  store data from ALU
- mau_ready  output  1  MAU idle, can accept
- mem_req  output  1  bus request, held until ack
- mem_we  output  1  1 = write
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_wstrb  output  4  byte write strobes (0 on reads)
- mem_ack  input  1  bus completion; read data valid on the same cycle
- mem_rdata  input  32  read word
- mau_done  output  1  one-cycle pulse, op finished
- mau_rdata  output  32  extended load result, valid with mau_done
- mau_err  output  1  one-cycle pulse with mau_done on illegal op, timeout or trapped misalign

Behaviour:
- Reset: state IDLE. Outputs after reset:
  - mau_ready=1
  - mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0
  - mau_done=0, mau_err=0, mau_rdata=0
  - Timeout counter=0.
- States: IDLE, BUSY, FAIL.
- Accept: mau_valid & mau_ready & (riscv_LOAD | riscv_STORE) at a clock edge. Request fields are latched at that edge.
- Illegal op (any one of these) goes to FAIL; no bus activity:
  - riscv_LOAD and riscv_STORE both high
  - load funct3 in {011, 110, 111}
  - store funct3 not in {000, 001, 010}
- IDLE -> BUSY on a legal accept:
  - mem_req=1 from the next cycle.
  - mem_addr, mem_we, mem_wdata and mem_wstrb are registered and stable for the whole of BUSY.
- Store lanes, where a = addr[1:0]:
  - SB: wstrb = 1<<a, wdata = {4{d[7:0]}}
  - SH: wstrb = a[1] ? 1100 : 0011, wdata = {2{d[15:0]}}
  - SW: wstrb = 1111, wdata = d
- Loads: wstrb = 0000. Byte/halfword lane is selected by a.
  - LB (000) / LH (001): sign-extend.
  - LBU (100) / LHU (101): zero-extend.
  - LW (010): pass through.
- BUSY, mem_ack=1: next cycle go IDLE.
  - mem_req=0.
  - mau_done=1 for one cycle.
  - For loads, mau_rdata = extended mem_rdata captured at the ack edge. mau_rdata holds until the next load completes.
- BUSY timeout: the counter increments each BUSY cycle without ack. At count == TIMEOUT_CYCLES-1 with no ack:
  - next cycle IDLE, mem_req=0, mau_done=1, mau_err=1.
  - mau_rdata unchanged.
- Ack and timeout in the same cycle: ack wins; no error.
- FAIL: lasts one cycle; mau_done=1, mau_err=1. Then IDLE.
- mau_ready=1 only in IDLE. mau_valid while not ready is ignored; upstream holds the op.
- Latency: accept at edge N, mem_req high in cycle N+1. Ack in cycle M (M ≥ N+1) gives mau_done in cycle M+1. Zero-wait memory gives 2 cycles accept-to-done.
- mem_ack outside BUSY is ignored.
- Reset mid-transaction: state returns to IDLE at that edge; mem_req drops; no mau_done is produced.
- Back-to-back: a new accept is possible in the cycle mau_done is high, because the state is IDLE.

Optional Feature:
- Macro: MAU_MISALIGN_TRAP_EN.
- Defined: an LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]≠00, goes to FAIL. Result: mau_err pulse, no bus access.
- Not defined: misaligned low address bits are forced to zero and the access proceeds normally.
  - Halfword: a[0] is ignored.
  - Word: a = 00.

Test Plan:
- SB, addr 0x00001003, data 0x000000A5, ack 1 cycle after req -> mem_addr=0x00001000, mem_wstrb=1000, mem_wdata=0xA5A5A5A5, mem_we=1; mau_done 2 cycles after accept; mau_err=0.
- LH, addr 0x00002002, mem_rdata=0x80011234 -> mau_rdata=0xFFFF8001. Same access as LHU -> 0x00008001.
- LB at 0x00000001 with mem_rdata=0x00007F80 -> mau_rdata=0x0000007F. LBU at 0x00000000 -> 0x00000080.
- LW, mem_ack never asserted, TIMEOUT_CYCLES=16 -> mem_req high exactly 16 cycles, then mau_done=1, mau_err=1, mau_ready=1, mau_rdata unchanged.
- SW accepted, reset asserted during the 3rd BUSY cycle -> mem_req=0 the following cycle, no mau_done, mau_ready=1; a following LW completes normally.
- LW at 0x00000101:
  - With MAU_MISALIGN_TRAP_EN: mau_err pulse 1 cycle after accept, mem_req never rises.
  - Without it: mem_addr=0x00000100, normal completion.
- Load with funct3=011 -> mau_err pulse 1 cycle after accept, no mem_req.

Source files
------------

// File: rtl/mau_lsu.sv
// mau_lsu: memory access unit between the ALU and writeback.
// Single-outstanding req/ack data-memory transaction with byte strobes,
// lane-replicated store data and sign/zero-extended load results.
// Optional build macro: MAU_MISALIGN_TRAP_EN (misaligned LH/LHU/SH/LW/SW
// trap to FAIL instead of having their low address bits forced to zero).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new op; mau_done may be high for the op just ended
// BUSY  | mem_req high, waiting for mem_ack or the timeout
// FAIL  | one-cycle error slot for an illegal/trapped op, no bus access
module mau_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mau_valid,
  input  logic        riscv_LOAD,
  input  logic        riscv_STORE,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr_toMAU,
  input  logic [31:0] data_toMAU,
  output logic        mau_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mau_done,
  output logic [31:0] mau_rdata,
  output logic        mau_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_lane_q, ld_lane_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        accept;
  logic        illegal;
  logic        misalign;
  logic [1:0]  lane;
  logic [3:0]  req_strb;
  logic [31:0] req_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign accept = mau_valid && (state_q == ST_IDLE) && (riscv_LOAD || riscv_STORE);

  // Decode the presented op: legality, effective byte lane, strobes and store data.
  always_comb begin
    lane = addr_toMAU[1:0];
    case (funct3[1:0])
      2'b01:   lane[0] = 1'b0;
      2'b10:   lane    = 2'b00;
      default: lane    = addr_toMAU[1:0];
    endcase

    misalign = 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
    misalign = ((funct3[1:0] == 2'b01) && addr_toMAU[0]) ||
               ((funct3[1:0] == 2'b10) && (addr_toMAU[1:0] != 2'b00));
`endif

    illegal = (riscv_LOAD && riscv_STORE) ||
              (riscv_LOAD  && ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111))) ||
              (riscv_STORE && (funct3[2] || (funct3[1:0] == 2'b11))) ||
              misalign;

    req_strb  = 4'b0000;
    req_wdata = 32'h0;
    if (riscv_STORE) begin
      case (funct3[1:0])
        2'b00: begin
          req_strb  = 4'b0001 << lane;
          req_wdata = {4{data_toMAU[7:0]}};
        end
        2'b01: begin
          req_strb  = lane[1] ? 4'b1100 : 4'b0011;
          req_wdata = {2{data_toMAU[15:0]}};
        end
        default: begin
          req_strb  = 4'b1111;
          req_wdata = data_toMAU;
        end
      endcase
    end
  end

  // Select the load lane from the returned word and extend it.
  always_comb begin
    case (ld_lane_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = ld_lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    ld_f3_d     = ld_f3_q;
    ld_lane_d   = ld_lane_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (illegal) begin
            state_d = ST_FAIL;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = ST_BUSY;
            cnt_d       = 8'd0;
            mem_we_d    = riscv_STORE;
            mem_addr_d  = {addr_toMAU[31:2], 2'b00};
            mem_wdata_d = req_wdata;
            mem_wstrb_d = req_strb;
            ld_f3_d     = funct3;
            ld_lane_d   = lane;
          end
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          done_d  = 1'b1;
          if (!mem_we_q) rdata_d = ld_ext;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      ld_f3_q     <= 3'b000;
      ld_lane_q   <= 2'b00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      ld_f3_q     <= ld_f3_d;
      ld_lane_q   <= ld_lane_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mau_ready = (state_q == ST_IDLE);
  assign mem_req   = (state_q == ST_BUSY);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mau_done  = done_q;
  assign mau_err   = err_q;
  assign mau_rdata = rdata_q;

endmodule

// File: tb/tb_mau_lsu.sv
// tb_mau_lsu: directed stimulus against a transaction-level model of mau_lsu.
// Build with +define+MAU_MISALIGN_TRAP_EN to cover the trap variant.
module tb_mau_lsu;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mau_valid = 1'b0, riscv_LOAD = 1'b0, riscv_STORE = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr_toMAU = 32'h0, data_toMAU = 32'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mau_ready, mem_req, mem_we, mau_done, mau_err;
  logic [31:0] mem_addr, mem_wdata, mau_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  mau_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .mau_valid(mau_valid), .riscv_LOAD(riscv_LOAD),
    .riscv_STORE(riscv_STORE), .funct3(funct3), .addr_toMAU(addr_toMAU),
    .data_toMAU(data_toMAU), .mau_ready(mau_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mau_done(mau_done), .mau_rdata(mau_rdata), .mau_err(mau_err)
  );

  int nchecks = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  function automatic int sz(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  // first byte lane touched: address rounded down to the access size
  function automatic int alane(input logic [1:0] a, input logic [2:0] f3);
    return int'(a) - (int'(a) % sz(f3));
  endfunction

  function automatic bit m_illegal(input bit ld, input bit st, input logic [2:0] f3, input logic [1:0] a);
    if (ld && st) return 1'b1;
    if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
`ifdef MAU_MISALIGN_TRAP_EN
    if ((int'(a) % sz(f3)) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] r;
    int al, s;
    al = alane(a, f3);
    s = sz(f3);
    r = 4'b0000;
    for (int i = 0; i < 4; i++) r[i] = (i >= al) && (i < al + s);
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int s;
    s = sz(f3);
    r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % s) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] v, mask;
    int s;
    s = sz(f3);
    v = rd >> (8 * alane(a, f3));
    if (s < 4) begin
      mask = (32'h1 << (8 * s)) - 32'h1;
      v = v & mask;
      if (!f3[2] && v[8*s-1]) v = v | ~mask;
    end
    return v;
  endfunction

  bit          m_busy = 1'b0, m_fail = 1'b0, m_done = 1'b0, m_err = 1'b0;
  bit          nd, ne;
  logic [31:0] m_rdata = 32'h0;
  int          m_cycles = 0;
  bit          t_load = 1'b0;
  logic [2:0]  t_f3 = 3'b000;
  logic [1:0]  t_a = 2'b00;
  logic [31:0] t_addr = 32'h0, t_d = 32'h0;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_busy = 0; m_fail = 0; m_done = 0; m_err = 0; m_rdata = 32'h0; m_cycles = 0;
    end else begin
      nd = 0; ne = 0;
      if (m_busy) begin
        if (mem_ack) begin
          nd = 1;
          if (t_load) m_rdata = m_load(t_f3, t_a, mem_rdata);
          m_busy = 0;
        end else if (m_cycles == T - 1) begin
          nd = 1; ne = 1; m_busy = 0;
        end else begin
          m_cycles++;
        end
      end else if (m_fail) begin
        m_fail = 0;
      end else if (mau_valid && (riscv_LOAD || riscv_STORE)) begin
        if (m_illegal(riscv_LOAD, riscv_STORE, funct3, addr_toMAU[1:0])) begin
          m_fail = 1; nd = 1; ne = 1;
        end else begin
          m_busy = 1; m_cycles = 0;
          t_load = riscv_LOAD; t_f3 = funct3; t_a = addr_toMAU[1:0];
          t_addr = addr_toMAU; t_d = data_toMAU;
        end
      end
      m_done = nd; m_err = ne;
    end
  end

  // ---------------- compare + monitor (negedge) ----------------
  bit          chk_en = 1'b0;
  int          cyc = 0;
  int          req_cnt = 0, done_cnt = 0, done_cyc = 0;
  bit          done_err = 1'b0;
  bit          cap_valid = 1'b0, cap_we = 1'b0;
  logic [31:0] cap_addr = 32'h0, cap_wdata = 32'h0;
  logic [3:0]  cap_strb = 4'h0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("ready", 32'(mau_ready), 32'(!(m_busy || m_fail)));
      chk("mem_req", 32'(mem_req), 32'(m_busy));
      chk("done", 32'(mau_done), 32'(m_done));
      chk("err", 32'(mau_err), 32'(m_err));
      chk("rdata", mau_rdata, m_rdata);
      if (m_busy) begin
        chk("mem_we", 32'(mem_we), 32'(!t_load));
        chk("mem_addr", mem_addr, {t_addr[31:2], 2'b00});
        chk("mem_wstrb", 32'(mem_wstrb), t_load ? 32'h0 : 32'(m_strb(t_f3, t_a)));
        if (!t_load) chk("mem_wdata", mem_wdata, m_wdata(t_f3, t_d));
      end
    end
    if (mem_req) begin
      req_cnt++;
      if (!cap_valid) begin
        cap_valid = 1; cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata; cap_strb = mem_wstrb;
      end
    end
    if (mau_done) begin
      done_cnt++; done_cyc = cyc; done_err = mau_err;
    end
  end

  // ---------------- stimulus ----------------
  int acc = 0, base_req = 0, base_done = 0, req_d = 0, done_d = 0;

  // ack_dly < 0: never ack. rst_at > 0: assert reset in that BUSY cycle.
  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int ack_dly, input logic [31:0] rd, input int rst_at);
    bit ok;
    @(negedge clk); #1;
    base_req = req_cnt; base_done = done_cnt; cap_valid = 0;
    mau_valid = 1; riscv_LOAD = ld; riscv_STORE = st; funct3 = f3; addr_toMAU = a; data_toMAU = d;
    @(posedge clk); #1;
    acc = cyc;
    mau_valid = 0; riscv_LOAD = 0; riscv_STORE = 0; addr_toMAU = ~a; data_toMAU = ~d;
    if (ack_dly >= 0 || rst_at > 0) begin
      ok = 0;
      for (int k = 0; k < 4 && !ok; k++) begin
        @(negedge clk); #1;
        ok = mem_req;
      end
      chk("req_rise_bound", 32'(ok), 32'h1);
      if (ack_dly >= 0) begin
        repeat (ack_dly) begin @(negedge clk); #1; end
        mem_ack = 1; mem_rdata = rd;
        @(negedge clk); #1;
        mem_ack = 0; mem_rdata = 32'hDEADBEEF;
      end else begin
        repeat (rst_at - 1) begin @(negedge clk); #1; end
        reset = 1;
        @(negedge clk); #1;
        reset = 0;
        chk("rst_req_low", 32'(mem_req), 32'h0);
        chk("rst_ready", 32'(mau_ready), 32'h1);
      end
    end
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk); #1;
      ok = mau_ready && !mau_done;
    end
    chk("idle_bound", 32'(ok), 32'h1);
    req_d = req_cnt - base_req;
    done_d = done_cnt - base_done;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk); #1;
    chk("rst_ready_lit", 32'(mau_ready), 32'h1);
    chk("rst_req_lit", 32'(mem_req), 32'h0);
    chk("rst_we_lit", 32'(mem_we), 32'h0);
    chk("rst_strb_lit", 32'(mem_wstrb), 32'h0);
    chk("rst_addr_lit", mem_addr, 32'h0);
    chk("rst_wdata_lit", mem_wdata, 32'h0);
    chk("rst_done_lit", 32'({mau_done, mau_err}), 32'h0);
    chk("rst_rdata_lit", mau_rdata, 32'h0);
    reset = 0;

    // SB, zero-wait ack: done one edge after the accept edge (2 cycles)
    do_op(0, 1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0, -1);
    chk("sb_addr", cap_addr, 32'h0000_1000);
    chk("sb_strb", 32'(cap_strb), 32'h8);
    chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    chk("sb_we", 32'(cap_we), 32'h1);
    chk("sb_latency", 32'(done_cyc - acc), 32'd1);
    chk("sb_err", 32'(done_err), 32'h0);

    do_op(1, 0, 3'b001, 32'h0000_2002, 32'h0, 2, 32'h8001_1234, -1);
    chk("lh", mau_rdata, 32'hFFFF_8001);
    do_op(1, 0, 3'b101, 32'h0000_2002, 32'h0, 0, 32'h8001_1234, -1);
    chk("lhu", mau_rdata, 32'h0000_8001);
    do_op(1, 0, 3'b000, 32'h0000_0001, 32'h0, 1, 32'h0000_7F80, -1);
    chk("lb", mau_rdata, 32'h0000_007F);
    do_op(1, 0, 3'b100, 32'h0000_0000, 32'h0, 0, 32'h0000_7F80, -1);
    chk("lbu", mau_rdata, 32'h0000_0080);

    // LW never acked: exactly T request cycles, then error done
    do_op(1, 0, 3'b010, 32'h0000_0010, 32'h0, -1, 32'h0, -1);
    chk("to_req_cycles", 32'(req_d), 32'd16);
    chk("to_done", 32'(done_d), 32'd1);
    chk("to_err", 32'(done_err), 32'h1);
    chk("to_rdata_held", mau_rdata, 32'h0000_0080);

    // SW interrupted by reset in its 3rd BUSY cycle, then a normal LW
    do_op(0, 1, 3'b010, 32'h0000_0200, 32'h1234_5678, -1, 32'h0, 3);
    chk("rst_no_done", 32'(done_d), 32'd0);
    chk("rst_req_cycles", 32'(req_d), 32'd3);
    do_op(1, 0, 3'b010, 32'h0000_0104, 32'h0, 0, 32'hCAFE_F00D, -1);
    chk("lw_after_rst", mau_rdata, 32'hCAFE_F00D);

    // misaligned LW
`ifdef MAU_MISALIGN_TRAP_EN
    do_op(1, 0, 3'b010, 32'h0000_0101, 32'h0, -1, 32'h0, -1);
    chk("mis_err", 32'(done_err), 32'h1);
    chk("mis_latency", 32'(done_cyc - acc), 32'd0);
    chk("mis_no_req", 32'(req_d), 32'd0);
`else
    do_op(1, 0, 3'b010, 32'h0000_0101, 32'h0, 0, 32'h0BAD_F00D, -1);
    chk("mis_addr", cap_addr, 32'h0000_0100);
    chk("mis_err", 32'(done_err), 32'h0);
    chk("mis_rdata", mau_rdata, 32'h0BAD_F00D);
`endif

    // illegal ops: error pulse in the cycle after accept, no bus activity
    do_op(1, 0, 3'b011, 32'h0000_0040, 32'h0, -1, 32'h0, -1);
    chk("ill_ld_err", 32'(done_err), 32'h1);
    chk("ill_ld_latency", 32'(done_cyc - acc), 32'd0);
    chk("ill_ld_no_req", 32'(req_d), 32'd0);
    do_op(0, 1, 3'b100, 32'h0000_0040, 32'h0, -1, 32'h0, -1);
    chk("ill_st_err", 32'(done_err), 32'h1);
    do_op(1, 1, 3'b010, 32'h0000_0040, 32'h0, -1, 32'h0, -1);
    chk("ill_both_err", 32'(done_err), 32'h1);
    chk("ill_both_no_req", 32'(req_d), 32'd0);

    // SH upper half
    do_op(0, 1, 3'b001, 32'h0000_0006, 32'h1234_BEEF, 0, 32'h0, -1);
    chk("sh_strb", 32'(cap_strb), 32'hC);
    chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);

    // back-to-back: valid held, memory acks every request immediately
    @(negedge clk); #1;
    base_done = done_cnt;
    mem_rdata = 32'h1122_3344;
    mau_valid = 1; riscv_LOAD = 1; funct3 = 3'b010; addr_toMAU = 32'h0000_0040;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      mem_ack = mem_req;
    end
    mau_valid = 0; riscv_LOAD = 0;
    @(negedge clk); #1;
    mem_ack = 0;
    repeat (3) begin @(negedge clk); #1; end
    chk("b2b_dones", 32'(done_cnt - base_done), 32'd3);
    chk("b2b_rdata", mau_rdata, 32'h1122_3344);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end
endmodule
